// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one frame-buffer RAM between VGA scanout and a client.
// Define FB_VBLANK_WRITE_EN to restrict client writes to vertical blanking.
module vga_fb_arbiter #(
  parameter int XW    = 8,
  parameter int YW    = 8,
  parameter int SHIFT = 2,
  parameter int DW    = 12
) (
  input  logic               clk_vga,
  input  logic               rst_n,
  input  logic [10:0]        hc_visible,
  input  logic [10:0]        vc_visible,
  input  logic               hs,
  input  logic               vs,
  output logic [DW-1:0]      pix,
  output logic               hs_o,
  output logic               vs_o,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [XW+YW-1:0]   req_addr,
  input  logic [DW-1:0]      req_wdata,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               frame_start,
  output logic [XW+YW-1:0]   mem_addr,
  output logic               mem_we,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam logic [10:0] PMASK = 11'((1 << SHIFT) - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t state, state_nxt;

  logic              visible;
  logic              slot;
  logic [10:0]       hm1;
  logic [10:0]       vm1;
  logic [XW-1:0]     disp_x;
  logic [YW-1:0]     disp_y;
  logic              wr_block;
  logic              xfer;
  logic              rd_acc;
  logic              vs_q;
  logic              vs_rise;
  logic              vs_fall;
  logic              hs_d1;
  logic              vs_d1;
  logic              vis_d1;
  logic              vis_d2;
  logic              disp_p1;
  logic              rd_p1;
  logic [DW-1:0]     pix_hold;

  assign visible = (hc_visible != 11'd0) && (vc_visible != 11'd0);
  assign hm1     = hc_visible - 11'd1;
  assign vm1     = vc_visible - 11'd1;
  assign slot    = visible && ((hm1 & PMASK) == 11'd0) && (state == RUN);
  assign disp_x  = XW'(hm1 >> SHIFT);
  assign disp_y  = YW'(vm1 >> SHIFT);

`ifdef FB_VBLANK_WRITE_EN
  // writes wait for vertical blanking so a frame never shows a partial update
  assign wr_block = req_we && (vc_visible != 11'd0);
`else
  assign wr_block = 1'b0;
`endif

  assign req_ready = !slot && !wr_block;
  assign xfer      = req_valid && req_ready;
  assign rd_acc    = xfer && !req_we;
  assign mem_addr  = slot ? {disp_y, disp_x} : req_addr;
  assign mem_we    = xfer && req_we;
  assign mem_wdata = req_wdata;

  assign vs_rise = vs && !vs_q;
  assign vs_fall = !vs && vs_q;

  always_comb begin
    state_nxt = state;
    case (state)
      SYNC:    if (vs_rise) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      vs_q        <= 1'b1;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      hs_o        <= 1'b1;
      vs_o        <= 1'b1;
      vis_d1      <= 1'b0;
      vis_d2      <= 1'b0;
      disp_p1     <= 1'b0;
      rd_p1       <= 1'b0;
      pix_hold    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      vs_q        <= vs;
      hs_d1       <= hs;
      vs_d1       <= vs;
      hs_o        <= hs_d1;
      vs_o        <= vs_d1;
      vis_d1      <= visible;
      vis_d2      <= vis_d1;
      disp_p1     <= slot;
      rd_p1       <= rd_acc;
      rsp_valid   <= rd_p1;
      frame_start <= (state == RUN) && vs_fall;
      if (disp_p1) pix_hold <= mem_rdata;
      if (rd_p1)   rsp_data <= mem_rdata;
    end
  end

  assign pix = vis_d2 ? pix_hold : '0;

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

- Shares one single-port synchronous frame-buffer RAM between the 1024x768 VGA scanout and an image-processing client.
- Sits between the VGA timing generator (hc/vc visible counters, hs/vs) and the frame-buffer BRAM.
- Turns scanout positions into frame-buffer reads, with pixel replication by 2^SHIFT. Display reads always have priority.
- Client reads and writes use every free memory cycle through a valid/ready handshake.
- Emits pixel data and sync signals re-aligned to each other.

## Interface
- XW, 8: frame-buffer x address bits (image width 2^XW).
- YW, 8: frame-buffer y address bits.
- SHIFT, 2: display upscale exponent. Each frame-buffer pixel covers 2^SHIFT x 2^SHIFT screen pixels.
- DW, 12: pixel/data width.
- clk_vga  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hc_visible  in  11  visible column, 1..1024; 0 outside the visible area.
- vc_visible  in  11  visible row, 1..768; 0 outside the visible area.
- hs, vs  in  1  sync from the timing generator, active low.
- pix  out  DW  pixel to DAC; 0 outside the visible area.
- hs_o, vs_o  out  1  hs/vs delayed to align with pix.
- req_valid  in  1  client request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  XW+YW  {y, x} frame-buffer address.
- req_wdata  in  DW  write data.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- rsp_valid  out  1  read data valid.
- rsp_data  out  DW  read data.
- frame_start  out  1  one-cycle pulse on each falling edge of vs, while in RUN.
- mem_addr  out  XW+YW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid one cycle after the address.

## Operation
- Visible: hc_visible != 0 and vc_visible != 0.
- Display slot: visible, and bits [SHIFT-1:0] of (hc_visible-1) are 0, and state = RUN.
- Display address: {(vc_visible-1)>>SHIFT, (hc_visible-1)>>SHIFT}, truncated to YW/XW bits.
- Grant rule: in a display slot, mem_addr carries the display address and mem_we = 0. Otherwise the client is granted.
- mem_addr, mem_we, mem_wdata and req_ready are combinational from the grant. req_ready = !display_slot (see Configuration for the extra write gating).
- Client transfer: occurs when req_valid and req_ready are both high.
  - Write: mem_we = 1 with req_addr and req_wdata in the same cycle.
  - Read: rsp_valid = 1 and rsp_data = mem_rdata exactly two cycles later (registered).
- The client must hold its request stable while req_ready = 0. No read ordering beyond in-order, fixed latency.
- Pixel pipeline: a display read issued at cycle t is captured into the pixel hold register at t+2 and then driven on pix.
  - pix holds that value until the next display slot's data arrives.
  - pix is forced to 0 when the visible flag, delayed 2 cycles, is low.
- State machine:
  - SYNC, entered at reset: no display slots, pix = 0, client granted every cycle.
  - SYNC to RUN on the first rising edge of vs.
  - RUN has no exit except reset.
- frame_start: a pulse on each falling edge of vs while in RUN.

## Timing
- Reset values: pix = 0, hs_o = 1, vs_o = 1, rsp_valid = 0, rsp_data = 0, frame_start = 0, state = SYNC.
- Latency:
  - hs/vs to hs_o/vs_o: 2 cycles.
  - Client read: 2 cycles.
  - Write: takes effect in the RAM at the acceptance edge.
- Client bandwidth in the visible area is (2^SHIFT-1)/2^SHIFT of cycles. It is 100% in blanking.
- Simultaneous client request and display slot: the display wins; req_ready = 0; no request is dropped.
- Reset asserted mid-read: the in-flight rsp_valid is suppressed. The client must reissue.
- SHIFT = 0: every visible cycle is a display slot, so the client only gets blanking cycles.

## Configuration
- FB_VBLANK_WRITE_EN:
  - Defined: client writes are accepted only while vc_visible == 0 (vertical blanking). During active lines, req_ready = 0 for req_we = 1, which gives tear-free updates. Reads are unaffected.
  - Undefined: writes are accepted in any non-display-slot cycle.

## Test plan
- Reset, then vs rising edge -> state RUN. frame_start pulses at the next vs falling edge. pix = 0 before RUN.
- Visible hc_visible = 1..8, vc_visible = 1, SHIFT = 2, RAM[{0,0}] = 0xABC, RAM[{0,1}] = 0x123 -> mem_addr = 0 at hc 1 and 1 at hc 5. pix = 0xABC for 4 cycles, then 0x123, offset by 2 cycles.
- Client read of addr 0x0105 held at hc_visible = 1 -> req_ready = 0 that cycle, accepted at hc 2. rsp_valid at hc 4 with RAM contents.
- Client write 0x5A5 to addr 0x0203 in hblank -> accepted immediately. A later read returns 0x5A5.
- With FB_VBLANK_WRITE_EN: a write at vc_visible = 10 stalls until vc_visible = 0. A read at the same time is accepted.
- rst_n pulled low one cycle after a read is accepted -> rsp_valid stays 0. All outputs go to their reset values asynchronously.
